pe_array_row_feeder: RTL and testbench

Transmit-side front end for the weight-stationary, latency-insensitive PE array. It accepts a job command and one flat word stream from the memory side, then emits per-row `{flag, data}` messages into the array's row inputs. The job runs in two phases: a weight-load phase (flag=1), then activation vectors (flag=0). The block sits between the memory/queue logic and the PE array's row-message ports, and the array's row ready signals backpressure it.

---
 rtl/pe_array_row_feeder.sv | 165 ++++++++++++++++
 tb/tb_pe_array_row_feeder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_row_feeder.sv
// Row feeder for the weight-stationary PE array: splits one word stream into per-row {flag,data} messages.
// Optional input-stall counter is enabled by defining PE_ARRAY_ROW_FEEDER_STALL_CNT_EN.

module pe_row_reg #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enq_i,
   input  logic [W-1:0] enq_data_i,
   input  logic         deq_rdy_i,
   output logic         can_enq_o,
   output logic         val_o,
   output logic [W-1:0] data_o
);
   logic         val_q;
   logic [W-1:0] data_q;

   // A full register still accepts when it is being drained in the same cycle.
   assign can_enq_o = ~val_q | deq_rdy_i;
   assign val_o     = val_q;
   assign data_o    = data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         val_q  <= 1'b0;
         data_q <= '0;
      end else if (enq_i) begin
         val_q  <= 1'b1;
         data_q <= enq_data_i;
      end else if (deq_rdy_i) begin
         val_q  <= 1'b0;
      end
   end
endmodule

module pe_array_row_feeder #(
   parameter int NUM_ROWS   = 2,
   parameter int NUM_COLS   = 2,
   parameter int BIT_WIDTH  = 8,
   parameter int NVEC_WIDTH = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NVEC_WIDTH-1:0]              start_msg,
   input  logic                               start_val,
   output logic                               start_rdy,
   input  logic [BIT_WIDTH-1:0]               in_msg,
   input  logic                               in_val,
   output logic                               in_rdy,
   output logic [NUM_ROWS-1:0][BIT_WIDTH:0]   row_send_msg,
   output logic [NUM_ROWS-1:0]                row_send_val,
   input  logic [NUM_ROWS-1:0]                row_send_rdy,
   output logic                               done,
   output logic [31:0]                        stall_cycles
);
   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

   state_t                state_q;
   logic [RW-1:0]         row_q;
   logic [CW-1:0]         col_q;
   logic [NVEC_WIDTH-1:0] nvec_q;
   logic [NVEC_WIDTH-1:0] vec_q;
   logic                  done_q;

   logic [NUM_ROWS-1:0]   can_enq;
   logic [NUM_ROWS-1:0]   enq;
   logic [BIT_WIDTH:0]    enq_data;
   logic                  busy, accept, start_fire, last_row, last_col;

   assign busy       = (state_q == LOAD) || (state_q == STREAM);
   assign in_rdy     = busy & can_enq[row_q];
   assign accept     = in_val & in_rdy;
   assign start_rdy  = (state_q == IDLE);
   assign start_fire = start_rdy & start_val;
   assign last_row   = (row_q == RW'(NUM_ROWS - 1));
   assign last_col   = (col_q == CW'(NUM_COLS - 1));
   assign enq_data   = {state_q == LOAD, in_msg};
   assign done       = done_q;

   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      assign enq[r] = accept & (row_q == RW'(r));
      pe_row_reg #(.W(BIT_WIDTH + 1)) u_reg (
         .clk        (clk),
         .reset      (reset),
         .enq_i      (enq[r]),
         .enq_data_i (enq_data),
         .deq_rdy_i  (row_send_rdy[r]),
         .can_enq_o  (can_enq[r]),
         .val_o      (row_send_val[r]),
         .data_o     (row_send_msg[r])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         nvec_q  <= '0;
         vec_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_fire) begin
                  nvec_q  <= start_msg;
                  row_q   <= '0;
                  col_q   <= '0;
                  vec_q   <= '0;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               // Row-major weight order: a row's columns arrive back to back.
               if (accept) begin
                  if (last_col) begin
                     col_q <= '0;
                     row_q <= last_row ? '0 : row_q + RW'(1);
                     if (last_row) state_q <= (nvec_q == '0) ? DRAIN : STREAM;
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
               end
            end
            STREAM: begin
               if (accept) begin
                  if (last_row) begin
                     row_q <= '0;
                     vec_q <= vec_q + NVEC_WIDTH'(1);
                     if (vec_q == nvec_q - NVEC_WIDTH'(1)) state_q <= DRAIN;
                  end else begin
                     row_q <= row_q + RW'(1);
                  end
               end
            end
            DRAIN: begin
               if (~|row_send_val) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef PE_ARRAY_ROW_FEEDER_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        stall_q <= '0;
      else if (start_fire)               stall_q <= '0;
      else if (busy & in_val & ~in_rdy)  stall_q <= stall_q + 32'd1;
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pe_array_row_feeder.sv
// Self-checking bench for pe_array_row_feeder: per-row expected message queues built from the
// job rules (word k -> row k/COLS during load, row k%ROWS during stream) plus directed scenarios.
`timescale 1ns/1ps
module tb_pe_array_row_feeder;
   localparam int R  = 2;
   localparam int C  = 2;
   localparam int BW = 8;
   localparam int NW = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NW-1:0]         start_msg;
   logic                  start_val;
   logic                  start_rdy;
   logic [BW-1:0]         in_msg;
   logic                  in_val;
   logic                  in_rdy;
   logic [R-1:0][BW:0]    row_send_msg;
   logic [R-1:0]          row_send_val;
   logic [R-1:0]          row_send_rdy;
   logic                  done;
   logic [31:0]           stall_cycles;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pe_array_row_feeder #(.NUM_ROWS(R), .NUM_COLS(C), .BIT_WIDTH(BW), .NVEC_WIDTH(NW)) dut (
      .clk(clk), .reset(reset),
      .start_msg(start_msg), .start_val(start_val), .start_rdy(start_rdy),
      .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy),
      .row_send_msg(row_send_msg), .row_send_val(row_send_val), .row_send_rdy(row_send_rdy),
      .done(done), .stall_cycles(stall_cycles)
   );

   // Reference: job phase, word count, per-row expected queues and a log of what actually left each row.
   typedef enum int {P_IDLE, P_LOAD, P_STREAM, P_DRAIN} ph_t;
   ph_t         m_ph = P_IDLE;
   int          m_k = 0, m_n = 0, m_stall = 0;
   logic        exp_done = 1'b0;
   logic [BW:0] exp_mem [R][1024];
   logic [BW:0] slog    [R][1024];
   int          wr [R];
   int          rd [R];
   ph_t         s_ph;
   int          s_tr;
   logic        s_ir, s_empty;
   logic [BW:0] dq [$];

   initial for (int r = 0; r < R; r++) begin wr[r] = 0; rd[r] = 0; end

   always @(negedge clk) begin
      if (!reset) begin
         m_ph = P_IDLE; m_k = 0; m_stall = 0; exp_done = 1'b0;
         for (int r = 0; r < R; r++) rd[r] = wr[r];
      end else begin
         s_ph = m_ph;
         s_tr = (s_ph == P_LOAD) ? (m_k / C) : (m_k % R);
         s_ir = (s_ph == P_LOAD || s_ph == P_STREAM) && ((wr[s_tr] == rd[s_tr]) || row_send_rdy[s_tr]);
         n_cmp++;
         if (start_rdy !== (s_ph == P_IDLE)) begin
            n_err++; $display("FAIL start_rdy: got %b want %b", start_rdy, s_ph == P_IDLE);
         end
         n_cmp++;
         if (in_rdy !== s_ir) begin
            n_err++; $display("FAIL in_rdy: got %b want %b (k=%0d)", in_rdy, s_ir, m_k);
         end
         s_empty = 1'b1;
         for (int r = 0; r < R; r++) begin
            if (wr[r] != rd[r]) s_empty = 1'b0;
            n_cmp++;
            if (row_send_val[r] !== (wr[r] != rd[r])) begin
               n_err++; $display("FAIL row%0d_val: got %b want %b", r, row_send_val[r], wr[r] != rd[r]);
            end else if (wr[r] != rd[r]) begin
               n_cmp++;
               if (row_send_msg[r] !== exp_mem[r][rd[r] % 1024]) begin
                  n_err++; $display("FAIL row%0d_msg: got %h want %h", r, row_send_msg[r], exp_mem[r][rd[r] % 1024]);
               end
            end
         end
         n_cmp++;
         if (done !== exp_done) begin
            n_err++; $display("FAIL done: got %b want %b", done, exp_done);
         end
         n_cmp++;
         if (stall_cycles !== 32'(m_stall)) begin
            n_err++; $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, m_stall);
         end
         exp_done = 1'b0;
         for (int r = 0; r < R; r++)
            if (wr[r] != rd[r] && row_send_rdy[r]) begin
               slog[r][rd[r] % 1024] = row_send_msg[r];
               rd[r]++;
            end
         if (s_ir && in_val) begin
            exp_mem[s_tr][wr[s_tr] % 1024] = {s_ph == P_LOAD, in_msg};
            wr[s_tr]++;
            m_k++;
            if (s_ph == P_LOAD && m_k == R * C) begin
               m_k = 0; m_ph = (m_n == 0) ? P_DRAIN : P_STREAM;
            end else if (s_ph == P_STREAM && m_k == m_n * R) begin
               m_ph = P_DRAIN;
            end
         end
`ifdef PE_ARRAY_ROW_FEEDER_STALL_CNT_EN
         if ((s_ph == P_LOAD || s_ph == P_STREAM) && in_val && !s_ir) m_stall++;
`endif
         if (s_ph == P_DRAIN && s_empty) begin m_ph = P_IDLE; exp_done = 1'b1; end
         if (s_ph == P_IDLE && start_val) begin
            m_n = int'(start_msg); m_k = 0; m_ph = P_LOAD; m_stall = 0;
         end
      end
   end

   function automatic logic [R-1:0] rnd_rdy(input int p);
      logic [R-1:0] v;
      for (int r = 0; r < R; r++) v[r] = ($urandom_range(99) < p);
      return v;
   endfunction

   // Runs one job (optionally assuming the start was already taken) and returns in its done cycle.
   task automatic do_job(input int n, input int pval, input int prdy, input bit skip_start);
      int total, acc, cyc;
      bit got;
      total = R * C + n * R;
      cyc = 0;
      got = skip_start;
      start_msg = NW'(n);
      start_val = !skip_start;
      while (!got && cyc < 200) begin
         row_send_rdy = rnd_rdy(prdy);
         @(negedge clk); got = start_rdy;
         @(posedge clk); #1; cyc++;
      end
      start_val = 1'b0;
      acc = 0;
      while (got && acc < total && cyc < 20000) begin
         in_val = ($urandom_range(99) < pval);
         in_msg = (dq.size() > 0) ? dq[0][BW-1:0] : BW'($urandom);
         row_send_rdy = rnd_rdy(prdy);
         @(negedge clk);
         if (in_val && in_rdy) begin
            acc++;
            if (dq.size() > 0) dq.delete(0);
         end
         @(posedge clk); #1; cyc++;
      end
      in_val = 1'b0;
      got = 1'b0;
      while (acc == total && !got && cyc < 20000) begin
         row_send_rdy = rnd_rdy(prdy);
         @(posedge clk); #1; cyc++;
         got = done;
      end
      n_cmp++;
      if (!got) begin
         n_err++; $display("FAIL job_timeout: accepted %0d of %0d words, done never seen", acc, total);
      end else begin
         n_cmp++;
         if (row_send_val !== '0 || in_rdy !== 1'b0 || start_rdy !== 1'b1) begin
            n_err++; $display("FAIL done_cycle_state: val=%b in_rdy=%b start_rdy=%b want 0/0/1", row_send_val, in_rdy, start_rdy);
         end
      end
      row_send_rdy = '1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start_val = 1'b0; start_msg = '0; in_val = 1'b0; in_msg = '0; row_send_rdy = '1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (row_send_val !== '0 || row_send_msg !== '0 || in_rdy !== 1'b0 || start_rdy !== 1'b1 ||
          done !== 1'b0 || stall_cycles !== 32'd0) begin
         n_err++; $display("FAIL reset_state: val=%b msg=%h in_rdy=%b start_rdy=%b done=%b stall=%0d",
                           row_send_val, row_send_msg, in_rdy, start_rdy, done, stall_cycles);
      end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_load_n1();
      int b0, b1;
      logic [BW:0] w0 [3];
      logic [BW:0] w1 [3];
      w0 = '{9'h111, 9'h122, 9'h055};
      w1 = '{9'h133, 9'h144, 9'h066};
      b0 = rd[0]; b1 = rd[1];
      dq = '{9'h11, 9'h22, 9'h33, 9'h44, 9'h55, 9'h66};
      do_job(1, 100, 100, 1'b0);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (slog[0][(b0 + i) % 1024] !== w0[i] || slog[1][(b1 + i) % 1024] !== w1[i]) begin
            n_err++; $display("FAIL load_n1_seq%0d: row0=%h row1=%h want %h %h", i,
                              slog[0][(b0 + i) % 1024], slog[1][(b1 + i) % 1024], w0[i], w1[i]);
         end
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b want 0", done); end
   endtask

   task automatic test_n0();
      do_job(0, 100, 100, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (in_rdy !== 1'b0 || row_send_val !== '0) begin
            n_err++; $display("FAIL n0_idle: in_rdy=%b val=%b want 0/0", in_rdy, row_send_val);
         end
      end
   endtask

   task automatic test_passthrough();
      int acc, cyc;
      start_msg = NW'(4); start_val = 1'b1;
      @(posedge clk); #1;
      start_val = 1'b0;
      acc = 0; cyc = 0;
      while (acc < R * C + 4 * R && cyc < 100) begin
         in_val = 1'b1; in_msg = BW'($urandom); row_send_rdy = '1;
         @(negedge clk);
         n_cmp++;
         if (in_rdy !== 1'b1) begin n_err++; $display("FAIL passthrough_rdy: got %b want 1 at word %0d", in_rdy, acc); end
         if (in_rdy) acc++;
         @(posedge clk); #1; cyc++;
      end
      in_val = 1'b0;
      n_cmp++;
      if (cyc !== R * C + 4 * R) begin n_err++; $display("FAIL passthrough_rate: %0d cycles want %0d", cyc, R * C + 4 * R); end
      cyc = 0;
      while (!done && cyc < 50) begin @(posedge clk); #1; cyc++; end
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL passthrough_done: timeout"); end
   endtask

   task automatic test_backpressure();
      int acc, cyc, win;
      logic [BW:0] hold;
      bit inwin;
      start_msg = NW'(6); start_val = 1'b1;
      @(posedge clk); #1;
      start_val = 1'b0;
      acc = 0; cyc = 0; win = 0; hold = '0;
      while (acc < R * C + 6 * R && cyc < 500) begin
         in_val = 1'b1; in_msg = BW'($urandom);
         inwin = (acc >= R * C + 2) && (win < 10);
         row_send_rdy = inwin ? 2'b01 : 2'b11;
         @(negedge clk);
         if (inwin) begin
            if (win == 0) hold = row_send_msg[1];
            n_cmp++;
            if (row_send_val[1] !== 1'b1 || row_send_msg[1] !== hold) begin
               n_err++; $display("FAIL bp_stable: val=%b msg=%h want 1 %h", row_send_val[1], row_send_msg[1], hold);
            end
            win++;
         end
         if (in_val && in_rdy) acc++;
         @(posedge clk); #1; cyc++;
      end
      in_val = 1'b0; row_send_rdy = '1;
      cyc = 0;
      while (!done && cyc < 50) begin @(posedge clk); #1; cyc++; end
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL bp_done: timeout"); end
   endtask

   task automatic test_reset_mid();
      int acc, cyc;
      start_msg = NW'(4); start_val = 1'b1;
      @(posedge clk); #1;
      start_val = 1'b0;
      acc = 0; cyc = 0;
      while (acc < R * C + 3 && cyc < 100) begin
         in_val = 1'b1; in_msg = BW'($urandom); row_send_rdy = 2'b10;
         @(negedge clk);
         if (in_rdy) acc++;
         @(posedge clk); #1; cyc++;
      end
      in_val = 1'b0;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (row_send_val !== '0 || start_rdy !== 1'b1 || in_rdy !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL reset_mid: val=%b start_rdy=%b in_rdy=%b done=%b", row_send_val, start_rdy, in_rdy, done);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      row_send_rdy = '1;
      do_job(2, 90, 90, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_job(1, 80, 80, 1'b0);
      start_msg = NW'(2); start_val = 1'b1;
      n_cmp++;
      if (start_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_start_rdy: got %b want 1", start_rdy); end
      @(posedge clk); #1;
      start_val = 1'b0;
      n_cmp++;
      if (start_rdy !== 1'b0 || in_rdy !== 1'b1) begin
         n_err++; $display("FAIL b2b_load: start_rdy=%b in_rdy=%b want 0/1", start_rdy, in_rdy);
      end
      do_job(2, 80, 80, 1'b1);
   endtask

   task automatic test_random();
      for (int j = 0; j < 8; j++)
         do_job(int'($urandom_range(5)), int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 1'b0);
   endtask

   task automatic test_max_n();
      do_job((1 << NW) - 1, 100, 100, 1'b0);
   endtask

   initial begin
      test_reset();
      test_load_n1();
      test_n0();
      test_passthrough();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_max_n();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
